// File: rtl/weight_fetch_seq_if.sv
// Row stream between the weight fetch sequencer and the PE/MAC array.
// The sequencer drives the row, its qualifiers and the lane mask; the
// array answers with Ready_out. A row moves when W_valid && Ready_out.
interface weight_fetch_seq_if #(
    parameter int ROW_W = 128
);
    logic [ROW_W-1:0] W_row;
    logic             W_valid;
    logic             Ready_out;
    logic [3:0]       W_lane_mask;
    logic             W_last;
    logic             W_final;

    // Sequencer side: produces rows, observes back-pressure.
    modport master (
        output W_row,
        output W_valid,
        output W_lane_mask,
        output W_last,
        output W_final,
        input  Ready_out
    );

    // Array side: consumes rows, applies back-pressure.
    modport slave (
        input  W_row,
        input  W_valid,
        input  W_lane_mask,
        input  W_last,
        input  W_final,
        output Ready_out
    );
endinterface

// File: rtl/weight_fetch_seq.sv
// Read-side sequencer for the 19-row x 128-bit weight memory.
// A layer command walks the rows of one layer, registers each row read
// back from the memory and streams it to the PE/MAC array, repeating the
// row set once per pass. A per-lane mask marks the 32-bit lanes in use.
module weight_fetch_seq #(
    parameter int ADDR_W = 5,
    parameter int ROW_W  = 128,
    parameter int PASS_W = 8
) (
    input  logic              Clock,
    input  logic              Res,
    input  logic              Start,
    input  logic [2:0]        Layer_sel,
    input  logic [PASS_W-1:0] Num_pass,
    input  logic [ROW_W-1:0]  mem_out,
    output logic [ADDR_W-1:0] Addr_mem_w,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    weight_fetch_seq_if.master w_if
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [PASS_W-1:0] PASS_ONE = PASS_W'(1);

    state_t              state_q,      state_d;
    logic [ADDR_W-1:0]   addr_q,       addr_d;
    logic [ADDR_W-1:0]   base_q,       base_d;
    logic [3:0]          rows_q,       rows_d;
    logic [3:0]          mask_q,       mask_d;
    logic [PASS_W-1:0]   num_pass_q,   num_pass_d;
    logic [3:0]          row_cnt_q,    row_cnt_d;
    logic [PASS_W-1:0]   pass_cnt_q,   pass_cnt_d;
    logic [ROW_W-1:0]    w_row_q,      w_row_d;
    logic                w_valid_q,    w_valid_d;
    logic                w_last_q,     w_last_d;
    logic                w_final_q,    w_final_d;
    logic                done_q,       done_d;
    logic                err_q,        err_d;

    // Layer table lookup results for the current Layer_sel.
    logic [ADDR_W-1:0]   tbl_base;
    logic [3:0]          tbl_rows;
    logic [3:0]          tbl_mask;

    logic                load_en;
    logic                last_row;
    logic                last_pass;
    logic                xfer;

    assign last_row  = (row_cnt_q == rows_q - 4'd1);
    assign last_pass = (pass_cnt_q == num_pass_q - PASS_ONE);
    assign xfer      = w_valid_q && w_if.Ready_out;

    // Fixed layer table: first row, row count and active-lane mask.
    always_comb begin
        tbl_base = '0;
        tbl_rows = 4'd0;
        tbl_mask = 4'b0000;
        case (Layer_sel)
            3'd0: begin tbl_base = ADDR_W'(0);  tbl_rows = 4'd4; tbl_mask = 4'b1111; end
            3'd1: begin tbl_base = ADDR_W'(4);  tbl_rows = 4'd2; tbl_mask = 4'b1111; end
            3'd2: begin tbl_base = ADDR_W'(6);  tbl_rows = 4'd1; tbl_mask = 4'b1100; end
            3'd3: begin tbl_base = ADDR_W'(7);  tbl_rows = 4'd1; tbl_mask = 4'b1000; end
            3'd4: begin tbl_base = ADDR_W'(8);  tbl_rows = 4'd1; tbl_mask = 4'b1000; end
            3'd5: begin tbl_base = ADDR_W'(9);  tbl_rows = 4'd2; tbl_mask = 4'b1000; end
            3'd6: begin tbl_base = ADDR_W'(11); tbl_rows = 4'd4; tbl_mask = 4'b1100; end
            3'd7: begin tbl_base = ADDR_W'(15); tbl_rows = 4'd4; tbl_mask = 4'b1111; end
            default: begin tbl_base = '0; tbl_rows = 4'd0; tbl_mask = 4'b0000; end
        endcase
    end

    // Next-state, address walk, row register and pulse generation.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        base_d     = base_q;
        rows_d     = rows_q;
        mask_d     = mask_q;
        num_pass_d = num_pass_q;
        row_cnt_d  = row_cnt_q;
        pass_cnt_d = pass_cnt_q;
        w_row_d    = w_row_q;
        w_valid_d  = w_valid_q;
        w_last_d   = w_last_q;
        w_final_d  = w_final_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        load_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                addr_d = '0;
                // The cycle carrying Done still belongs to the finished
                // command, so a Start seen there is dropped.
                if (Start && !done_q) begin
                    if (Num_pass != '0) begin
                        base_d     = tbl_base;
                        rows_d     = tbl_rows;
                        mask_d     = tbl_mask;
                        num_pass_d = Num_pass;
                        row_cnt_d  = 4'd0;
                        pass_cnt_d = '0;
                        addr_d     = tbl_base;
                        state_d    = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                // Refill the output register whenever it is empty or being
                // taken this cycle; otherwise address and counters freeze.
                load_en = !w_valid_q || w_if.Ready_out;
                if (load_en) begin
                    w_row_d   = mem_out;
                    w_valid_d = 1'b1;
                    w_last_d  = last_row;
                    w_final_d = last_row && last_pass;
                    if (last_row) begin
                        addr_d     = base_q;
                        row_cnt_d  = 4'd0;
                        pass_cnt_d = pass_cnt_q + PASS_ONE;
                        if (last_pass) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        addr_d    = addr_q + ADDR_ONE;
                        row_cnt_d = row_cnt_q + 4'd1;
                    end
                end
            end

            ST_DRAIN: begin
                // Only the final row remains; wait for it to be taken.
                if (xfer) begin
                    w_valid_d = 1'b0;
                    w_last_d  = 1'b0;
                    w_final_d = 1'b0;
                    done_d    = 1'b1;
                    addr_d    = '0;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                addr_d    = '0;
                w_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Res) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            base_q     <= '0;
            rows_q     <= 4'd0;
            mask_q     <= 4'b0000;
            num_pass_q <= '0;
            row_cnt_q  <= 4'd0;
            pass_cnt_q <= '0;
            w_row_q    <= '0;
            w_valid_q  <= 1'b0;
            w_last_q   <= 1'b0;
            w_final_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            base_q     <= base_d;
            rows_q     <= rows_d;
            mask_q     <= mask_d;
            num_pass_q <= num_pass_d;
            row_cnt_q  <= row_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            w_row_q    <= w_row_d;
            w_valid_q  <= w_valid_d;
            w_last_q   <= w_last_d;
            w_final_q  <= w_final_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign Addr_mem_w       = addr_q;
    assign Busy             = (state_q != ST_IDLE);
    assign Done             = done_q;
    assign Err              = err_q;
    assign w_if.W_row       = w_row_q;
    assign w_if.W_valid     = w_valid_q;
    assign w_if.W_lane_mask = mask_q;
    assign w_if.W_last      = w_last_q;
    assign w_if.W_final     = w_final_q;

endmodule
